// File: rtl/imm_pkg.sv
// Shared types and field geometry for the immediate packer and its range check.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_I  = 2'b00,
        IMM_D  = 2'b01,
        IMM_B  = 2'b10,
        IMM_CB = 2'b11
    } imm_fmt_e;

    localparam int IMM_FIELD_W = 26;

    localparam int IMM_I_W    = 12;
    localparam int IMM_I_LSB  = 0;
    localparam int IMM_D_W    = 9;
    localparam int IMM_D_LSB  = 12;
    localparam int IMM_B_W    = 26;
    localparam int IMM_B_LSB  = 0;
    localparam int IMM_CB_W   = 19;
    localparam int IMM_CB_LSB = 5;

    typedef struct packed {
        logic [IMM_FIELD_W-1:0] imm26;
        logic                   fit;
    } imm_entry_t;

    // A value fits a w-bit signed field when every bit from w-1 up to 63 equals the sign bit.
    function automatic logic sign_fits(input logic [63:0] value, input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if ((i >= width - 1) && (value[i] != value[63])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/imm_pack_core.sv
// Combinational placement of a 64-bit signed immediate into the 26-bit field, with range check.
module imm_pack_core
    import imm_pkg::*;
(
    input  logic [63:0]            bus_imm,
    input  logic [1:0]             ctrl,
    output logic [IMM_FIELD_W-1:0] imm26,
    output logic                   fit
);

    imm_fmt_e fmt;

    assign fmt = imm_fmt_e'(ctrl);

    // Out-of-range values are still packed as their truncated low bits.
    always_comb begin
        imm26 = '0;
        fit   = 1'b0;
        unique case (fmt)
            IMM_I: begin
                imm26[IMM_I_LSB +: IMM_I_W] = bus_imm[IMM_I_W-1:0];
                fit = sign_fits(bus_imm, IMM_I_W);
            end
            IMM_D: begin
                imm26[IMM_D_LSB +: IMM_D_W] = bus_imm[IMM_D_W-1:0];
                fit = sign_fits(bus_imm, IMM_D_W);
            end
            IMM_B: begin
                imm26[IMM_B_LSB +: IMM_B_W] = bus_imm[IMM_B_W-1:0];
                fit = sign_fits(bus_imm, IMM_B_W);
            end
            IMM_CB: begin
                imm26[IMM_CB_LSB +: IMM_CB_W] = bus_imm[IMM_CB_W-1:0];
                fit = sign_fits(bus_imm, IMM_CB_W);
            end
            default: begin
                imm26 = '0;
                fit   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_field_packer.sv
// Immediate packer with a two-entry output queue; InReady comes straight from the queue count.
// Optional overflow counter on port ErrCnt when IMMPACK_ERRCNT_EN is defined.
module imm_field_packer
    import imm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   Reset_L,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [63:0]            BusImm,
    input  logic [1:0]             Ctrl,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [IMM_FIELD_W-1:0] Imm26,
    output logic                   Fit
`ifdef IMMPACK_ERRCNT_EN
    ,
    output logic [15:0]            ErrCnt
`endif
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    imm_entry_t             q_mem [0:1];
    imm_entry_t             new_entry;
    imm_entry_t             head_entry;
    logic                   head_ptr;
    logic                   tail_ptr;
    logic [1:0]             count;
    logic                   push;
    logic                   pop;
    logic [IMM_FIELD_W-1:0] pack_imm;
    logic                   pack_fit;

    imm_pack_core u_core (
        .bus_imm (BusImm),
        .ctrl    (Ctrl),
        .imm26   (pack_imm),
        .fit     (pack_fit)
    );

    assign new_entry  = '{imm26: pack_imm, fit: pack_fit};
    assign head_entry = q_mem[head_ptr];

    assign InReady  = (count != FULL);
    assign OutValid = (count != 2'd0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;

    // Gating on OutValid keeps the idle outputs at their reset values.
    assign Imm26 = OutValid ? head_entry.imm26 : '0;
    assign Fit   = OutValid ? head_entry.fit   : 1'b0;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            q_mem[0] <= '0;
            q_mem[1] <= '0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                q_mem[tail_ptr] <= new_entry;
                tail_ptr        <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef IMMPACK_ERRCNT_EN
    logic [15:0] err_cnt;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            err_cnt <= 16'd0;
        end else if (pop && !head_entry.fit && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign ErrCnt = err_cnt;
`endif

endmodule

// File: tb/tb_imm_field_packer.sv
// Scoreboard bench for imm_field_packer plus a round-trip sweep of imm_pack_core.
module tb_imm_field_packer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] bus_imm;
    logic [1:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] imm26;
    logic        fit;
`ifdef IMMPACK_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    logic [63:0] r_imm;
    logic [1:0]  r_ctrl;
    logic [25:0] r_imm26;
    logic        r_fit;

    typedef struct {
        logic [25:0] imm26;
        logic        fit;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_err  = 0;

    imm_field_packer #(.DEPTH(2)) dut (
        .CLK      (clk),
        .Reset_L  (rst_n),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .BusImm   (bus_imm),
        .Ctrl     (ctrl),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Imm26    (imm26),
        .Fit      (fit)
`ifdef IMMPACK_ERRCNT_EN
        ,
        .ErrCnt   (err_cnt)
`endif
    );

    imm_pack_core ref_core (
        .bus_imm (r_imm),
        .ctrl    (r_ctrl),
        .imm26   (r_imm26),
        .fit     (r_fit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares the head against the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(imm26), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_imm26", 64'(imm26), 64'(e.imm26));
                check("out_fit", 64'(fit), 64'(e.fit));
`ifdef IMMPACK_ERRCNT_EN
                check("err_cnt", 64'(err_cnt), 64'(exp_err));
`endif
                if (!e.fit) exp_err++;
            end
        end
    end

    task automatic send(input logic [1:0] c, input logic [63:0] v,
                        input logic [25:0] e26, input logic ef);
        int tries;
        tries    = 0;
        ctrl     = c;
        bus_imm  = v;
        in_valid = 1'b1;
        while (!in_ready && tries < 50) begin
            @(posedge clk); #1;
            tries++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_q.push_back('{e26, ef});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic sweep(input int n);
        int          w;
        int          lsb;
        longint      v;
        longint      lo;
        longint      hi;
        logic [63:0] fld;
        logic [63:0] se;
        logic [63:0] mask;
        int          sh;
        for (int i = 0; i < n; i++) begin
            r_ctrl = 2'($urandom_range(0, 3));
            r_imm  = {$urandom, $urandom};
            sh     = $urandom_range(0, 63);
            r_imm  = 64'($signed(r_imm) >>> sh);
            #1;
            case (r_ctrl)
                2'b00:   begin w = 12; lsb = 0;  end
                2'b01:   begin w = 9;  lsb = 12; end
                2'b10:   begin w = 26; lsb = 0;  end
                default: begin w = 19; lsb = 5;  end
            endcase
            v    = $signed(r_imm);
            lo   = -(longint'(1) << (w - 1));
            hi   = (longint'(1) << (w - 1)) - 1;
            mask = (64'd1 << w) - 64'd1;
            check("sweep_fit", 64'(r_fit), 64'((v >= lo) && (v <= hi)));
            check("sweep_stray_bits", 64'(r_imm26) & ~(mask << lsb), 64'd0);
            if (r_fit) begin
                fld = (64'(r_imm26) >> lsb) & mask;
                se  = 64'($signed(fld << (64 - w)) >>> (64 - w));
                check("sweep_roundtrip", se, r_imm);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bus_imm   = '0;
        ctrl      = 2'b00;
        r_imm     = '0;
        r_ctrl    = 2'b00;

        #3;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imm26", 64'(imm26), 64'd0);
        check("rst_fit", 64'(fit), 64'd0);
`ifdef IMMPACK_ERRCNT_EN
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
`endif
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed formats and range boundaries, streaming with OutReady high.
        out_ready = 1'b1;
        send(2'b00, 64'hFFFF_FFFF_FFFF_F800, 26'h0000800, 1'b1);
        send(2'b01, 64'd256,                 26'h0100000, 1'b0);
        send(2'b11, 64'h3FFFF,               26'h07FFFE0, 1'b1);
        send(2'b10, 64'hFFFF_FFFF_FE00_0000, 26'h2000000, 1'b1);
        send(2'b00, 64'd2047,                26'h00007FF, 1'b1);
        send(2'b00, 64'd2048,                26'h0000800, 1'b0);
        send(2'b00, 64'hFFFF_FFFF_FFFF_F7FF, 26'h00007FF, 1'b0);
        send(2'b01, 64'hFFFF_FFFF_FFFF_FF00, 26'h0100000, 1'b1);
        send(2'b01, 64'd255,                 26'h00FF000, 1'b1);
        send(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 26'h0FFFFE0, 1'b1);
        send(2'b11, 64'h40000,               26'h0800000, 1'b0);
        send(2'b10, 64'h200_0000,            26'h2000000, 1'b0);
        drain();

        // Backpressure: three offered back to back, only two accepted.
        out_ready = 1'b0;
        ctrl = 2'b00; bus_imm = 64'd5; in_valid = 1'b1;
        check("bp_ready_0", 64'(in_ready), 64'd1);
        exp_q.push_back('{26'h0000005, 1'b1});
        @(posedge clk); #1;
        check("bp_ready_1", 64'(in_ready), 64'd1);
        ctrl = 2'b10; bus_imm = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_q.push_back('{26'h3FFFFFF, 1'b1});
        @(posedge clk); #1;
        check("bp_ready_full", 64'(in_ready), 64'd0);
        ctrl = 2'b01; bus_imm = 64'd300;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("bp_still_full", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_head_stable", 64'(imm26), 64'h5);
        out_ready = 1'b1;
        send(2'b01, 64'd300, 26'h012C000, 1'b0);
        drain();

        // Reset with two entries queued discards them at once.
        out_ready = 1'b0;
        send(2'b00, 64'd1, 26'h0000001, 1'b1);
        send(2'b00, 64'd2, 26'h0000002, 1'b1);
        check("pre_rst_full", 64'(in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2'b11, 64'h123, 26'h0002460, 1'b1);
        check("post_rst_latency_valid", 64'(out_valid), 64'd1);
        check("post_rst_latency_imm", 64'(imm26), 64'h2460);
        drain();

        sweep(10000);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_field_packer.md
# imm_field_packer

Inverse of the datapath sign extender. Accepts a 64-bit signed immediate plus the 2-bit format select (I/D/B/CB), range-checks it against the format's field width, and packs it into the 26-bit instruction immediate field. Used by the instruction-rewrite/assembler path ahead of instruction memory writes. Buffered valid/ready on both sides. Two-entry output queue, so input ready is purely registered.

## Interface
Parameters:
- `DEPTH`, 2: output queue entries; only 2 is supported.

Ports:
- `CLK`  in  1  clock, all state on rising edge.
- `Reset_L`  in  1  asynchronous, active-low reset.
- `InValid`  in  1  input word offered.
- `InReady`  out  1  block can accept; depends only on internal state.
- `BusImm`  in  64  signed immediate value.
- `Ctrl`  in  2  format: 00 I (12b), 01 D (9b), 10 B (26b), 11 CB (19b).
- `OutValid`  out  1  head entry valid.
- `OutReady`  in  1  consumer accepts head.
- `Imm26`  out  26  packed immediate field.
- `Fit`  out  1  1 = value representable in the selected format.
- `ErrCnt`  out  16  overflow counter; present only with `IMMPACK_ERRCNT_EN`.

## Operation
- Input transfer: `InValid && InReady` at a clock edge. Output transfer: `OutValid && OutReady` at a clock edge.
- Field placement (bits not listed are 0):
  - Ctrl 00: `Imm26[11:0]=BusImm[11:0]`. Fit iff `BusImm[63:11]` are all equal.
  - Ctrl 01: `Imm26[20:12]=BusImm[8:0]`. Fit iff `BusImm[63:8]` are all equal.
  - Ctrl 10: `Imm26[25:0]=BusImm[25:0]`. Fit iff `BusImm[63:25]` are all equal.
  - Ctrl 11: `Imm26[23:5]=BusImm[18:0]`. Fit iff `BusImm[63:18]` are all equal.
- Packing and Fit are computed combinationally on input. The results are written into the queue tail on input transfer.
- An out-of-range value is still packed as its truncated low bits, with Fit=0. It is never dropped.
- Round-trip invariant: when Fit=1, sign-extending `Imm26` with the same Ctrl reproduces `BusImm` exactly.
- Queue: count 0..2 with head/tail pointers.
  - `InReady = (count != 2)`.
  - `OutValid = (count != 0)`.
  - Outputs show the head entry.
- Simultaneous push and pop at count 1: count stays 1; the new entry becomes the head on the next cycle.
- Pop at count 0 cannot occur. Push at count 2 is blocked.
- In-order delivery, no reordering, no loss.

## Timing
- Latency is 1 cycle: an input transferred at edge N is visible on `OutValid`/`Imm26`/`Fit` after edge N, provided earlier entries have drained.
- Throughput is 1 per cycle while `OutReady=1`.
- Reset values:
  - `InReady=1`, `OutValid=0`, `Imm26=0`, `Fit=0`, `ErrCnt=0`, count and pointers 0.
- Reset mid-operation: all queued entries are discarded immediately (asynchronous); no output transfer occurs in the reset cycle.
- `Imm26`/`Fit` hold stable while `OutValid=1 && OutReady=0`.

## Configuration
- `IMMPACK_ERRCNT_EN` defined:
  - Port `ErrCnt` and a 16-bit counter exist.
  - The counter increments on each output transfer with Fit=0.
  - It saturates at 0xFFFF and clears only on reset.
- `IMMPACK_ERRCNT_EN` undefined: no port, no counter; all other behaviour is identical.

## Structure
- Shared package `imm_pkg`:
  - Format enum (`IMM_I=2'b00`, `IMM_D=2'b01`, `IMM_B=2'b10`, `IMM_CB=2'b11`).
  - Per-format field width and LSB position constants.
  - Packed struct `{Imm26, Fit}` for the queue entries.
- One sub-module, `imm_pack_core`: the combinational pack plus range check, reused by the test bench's reference model.
- The queue and counter live in `imm_field_packer`.

## Test plan
- Ctrl=00, BusImm=0xFFFF_FFFF_FFFF_F800 (-2048), OutReady=1 -> the next cycle shows Imm26=0x0000800, Fit=1.
- Ctrl=01, BusImm=256 -> Imm26=0x0100000, Fit=0; with the macro defined, ErrCnt goes 0 -> 1 after the output transfer.
- Ctrl=11, BusImm=0x3FFFF -> Imm26=0x07FFFE0, Fit=1. Ctrl=10, BusImm=0xFFFF_FFFF_FE00_0000 -> Imm26=0x2000000, Fit=1.
- Backpressure: hold OutReady=0 and offer 3 words back to back -> 2 are accepted and InReady=0 from the second acceptance. Release OutReady -> words emerge in order with no loss or duplicates.
- Assert Reset_L=0 with 2 entries queued -> OutValid=0 and InReady=1 immediately. After release, the first new input emerges with 1-cycle latency.
- Random sweep of 10k vectors against `imm_pack_core` plus a sign-extend model -> round-trip holds whenever Fit=1, and Fit matches the range [-2^(w-1), 2^(w-1)-1].
